// File: rtl/gelato_warp_fetch_scheduler.sv
// Warp fetch scheduler: picks one eligible warp per cycle (LRR or GTR)
// and registers its PC/split index into a valid/ready output stage.
module gelato_warp_fetch_scheduler #(
    parameter int WARP_NUM   = 8,
    parameter int PC_W       = 32,
    parameter int SPLIT_W    = 4,
    parameter int GREEDY_MAX = 4,
    localparam int WARP_W    = (WARP_NUM > 2) ? $clog2(WARP_NUM) : 1,
    localparam int BURST_W   = $clog2(GREEDY_MAX + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rdy,
    input  logic                         mode,
    input  logic [WARP_NUM-1:0]          warp_valid,
    input  logic [WARP_NUM-1:0]          warp_stall,
    input  logic [WARP_NUM*PC_W-1:0]     warp_pc,
    input  logic [WARP_NUM*SPLIT_W-1:0]  warp_split,
    output logic [WARP_NUM-1:0]          selected,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_W-1:0]              out_pc,
    output logic [WARP_W-1:0]            out_warp,
    output logic [SPLIT_W-1:0]           out_split,
    input  logic                         done_valid,
    input  logic [WARP_W-1:0]            done_warp
);

    logic [WARP_NUM-1:0] in_flight;
    logic [WARP_NUM-1:0] elig;
    logic [WARP_NUM-1:0] clr;
    logic [WARP_NUM-1:0] onehot;
    logic [WARP_NUM-1:0] sel_q;
    logic [WARP_W-1:0]   last_warp;
    logic [WARP_W-1:0]   rr_pick;
    logic [WARP_W-1:0]   pick;
    logic [BURST_W-1:0]  burst_cnt;
    logic [PC_W-1:0]     pc_n;
    logic [SPLIT_W-1:0]  split_n;
    logic                greedy;
    logic                load;

    assign elig = warp_valid & ~warp_stall & ~in_flight;

    // Out-of-range done_warp values never match any slot.
    always_comb begin
        clr = '0;
        for (int i = 0; i < WARP_NUM; i++) begin
            clr[i] = rdy & done_valid & (done_warp == WARP_W'(i));
        end
    end

    // Scan from the far end so the nearest eligible warp wins last.
    always_comb begin : rr_scan
        logic [WARP_W:0] idx;
        idx     = '0;
        rr_pick = '0;
        for (int k = WARP_NUM; k >= 1; k--) begin
            idx = {1'b0, last_warp} + (WARP_W + 1)'(k);
            if (idx >= (WARP_W + 1)'(WARP_NUM)) begin
                idx = idx - (WARP_W + 1)'(WARP_NUM);
            end
            if (elig[idx[WARP_W-1:0]]) begin
                rr_pick = idx[WARP_W-1:0];
            end
        end
    end

    assign greedy = mode & elig[last_warp]
                  & (burst_cnt < BURST_W'(GREEDY_MAX));
    assign pick   = greedy ? last_warp : rr_pick;
    assign load   = rdy & (|elig) & (~out_valid | out_ready);

    always_comb begin
        pc_n    = '0;
        split_n = '0;
        onehot  = '0;
        for (int i = 0; i < WARP_NUM; i++) begin
            if (pick == WARP_W'(i)) begin
                pc_n      = warp_pc[i*PC_W +: PC_W];
                split_n   = warp_split[i*SPLIT_W +: SPLIT_W];
                onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_warp  <= '0;
            out_split <= '0;
            sel_q     <= '0;
            last_warp <= WARP_W'(WARP_NUM - 1);
            in_flight <= '0;
            burst_cnt <= '0;
        end else begin
            sel_q <= '0;
            if (rdy) begin
                in_flight <= (in_flight & ~clr) | (load ? onehot : '0);
                if (load) begin
                    out_valid <= 1'b1;
                    out_pc    <= pc_n;
                    out_warp  <= pick;
                    out_split <= split_n;
                    sel_q     <= onehot;
                    last_warp <= pick;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
                if (!mode) begin
                    burst_cnt <= '0;
                end else if (load) begin
                    if (pick != last_warp) begin
                        burst_cnt <= BURST_W'(1);
                    end else if (burst_cnt != BURST_W'(GREEDY_MAX)) begin
                        burst_cnt <= burst_cnt + BURST_W'(1);
                    end
                end
            end
        end
    end

    assign selected = sel_q & {WARP_NUM{rdy}};

endmodule

// File: tb/tb_gelato_warp_fetch_scheduler.sv
// Bench for gelato_warp_fetch_scheduler: directed phases plus random
// traffic, checked against a behavioural model of the scheduling rules.
module tb_gelato_warp_fetch_scheduler;

    localparam int N  = 6;
    localparam int PW = 16;
    localparam int SW = 4;
    localparam int G  = 3;
    localparam int WW = 3;

    logic          clk;
    logic          rst_n;
    logic          rdy;
    logic          mode;
    logic [N-1:0]  warp_valid;
    logic [N-1:0]  warp_stall;
    logic [N*PW-1:0] warp_pc;
    logic [N*SW-1:0] warp_split;
    logic [N-1:0]  selected;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pc;
    logic [WW-1:0] out_warp;
    logic [SW-1:0] out_split;
    logic          done_valid;
    logic [WW-1:0] done_warp;

    gelato_warp_fetch_scheduler #(
        .WARP_NUM(N), .PC_W(PW), .SPLIT_W(SW), .GREEDY_MAX(G)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .mode(mode),
        .warp_valid(warp_valid), .warp_stall(warp_stall),
        .warp_pc(warp_pc), .warp_split(warp_split),
        .selected(selected), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc),
        .out_warp(out_warp), .out_split(out_split),
        .done_valid(done_valid), .done_warp(done_warp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    bit            m_fl[N];
    int            m_last;
    int            m_burst;
    bit            m_ov;
    logic [PW-1:0] m_pc;
    int            m_warp;
    logic [SW-1:0] m_split;
    logic [N-1:0]  m_sel;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_fl[i] = 1'b0;
        m_last  = N - 1;
        m_burst = 0;
        m_ov    = 1'b0;
        m_pc    = '0;
        m_warp  = 0;
        m_split = '0;
        m_sel   = '0;
    endtask

    task automatic model_step();
        bit e[N];
        bit any;
        bit ld;
        int c;
        any = 1'b0;
        c   = -1;
        for (int i = 0; i < N; i++) begin
            e[i] = warp_valid[i] && !warp_stall[i] && !m_fl[i];
            any  = any | e[i];
        end
        m_sel = '0;
        if (!rdy) return;
        ld = any && (!m_ov || out_ready);
        if (mode && e[m_last] && m_burst < G) begin
            c = m_last;
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (c < 0 && e[(m_last + k) % N]) c = (m_last + k) % N;
            end
        end
        if (done_valid && int'(done_warp) < N) m_fl[done_warp] = 1'b0;
        if (ld) begin
            m_ov    = 1'b1;
            m_pc    = warp_pc[c*PW +: PW];
            m_split = warp_split[c*SW +: SW];
            m_warp  = c;
            m_fl[c] = 1'b1;
            m_sel   = N'(1) << c;
            if (mode) m_burst = (c == m_last) ? m_burst + 1 : 1;
            m_last  = c;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        if (!mode) m_burst = 0;
    endtask

    task automatic check_all();
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_pc", 64'(out_pc), 64'(m_pc));
        chk("out_warp", 64'(out_warp), 64'(m_warp));
        chk("out_split", 64'(out_split), 64'(m_split));
        chk("selected", 64'(selected), 64'(m_sel));
    endtask

    task automatic rand_pcs();
        for (int i = 0; i < N; i++) begin
            warp_pc[i*PW +: PW]    = PW'($urandom);
            warp_split[i*SW +: SW] = SW'($urandom);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Returns the warp loaded on the last edge, as an immediate done.
    task automatic done_last();
        done_valid = (m_sel != '0);
        done_warp  = WW'(m_warp);
    endtask

    initial begin
        rst_n      = 1'b0;
        rdy        = 1'b1;
        mode       = 1'b0;
        warp_valid = '0;
        warp_stall = '0;
        warp_pc    = '0;
        warp_split = '0;
        out_ready  = 1'b1;
        done_valid = 1'b0;
        done_warp  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();

        // LRR, all warps valid, done returned one cycle after issue
        warp_valid = '1;
        for (int i = 0; i < 8; i++) begin
            rand_pcs();
            cyc();
            chk("lrr_seq", 64'(out_warp), 64'(i % N));
            chk("lrr_sel", 64'(selected), 64'(N'(1) << (i % N)));
            done_last();
        end

        // LRR, only warps 4 and 1 valid
        warp_valid = 6'b010010;
        for (int i = 0; i < 6; i++) begin
            rand_pcs();
            cyc();
            done_last();
        end

        // GTR, warps 2 and 5 valid, immediate done
        mode       = 1'b1;
        warp_valid = 6'b100100;
        for (int i = 0; i < 12; i++) begin
            rand_pcs();
            cyc();
            done_last();
        end

        // Output stall for 4 cycles, then release
        mode       = 1'b0;
        warp_valid = '1;
        rand_pcs();
        cyc();
        done_last();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_pcs();
            cyc();
            chk("stall_sel", 64'(selected), 64'(0));
            done_valid = 1'b0;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_pcs();
            cyc();
            done_last();
        end

        // Asynchronous reset mid-burst
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_sel", 64'(selected), 64'(0));
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        done_valid = 1'b0;
        cyc();
        chk("rst_first", 64'(out_warp), 64'(0));

        // Warp 3 only: single issue, out-of-range done, then real done
        warp_valid = 6'b001000;
        for (int i = 0; i < 4; i++) cyc();
        done_valid = 1'b1;
        done_warp  = 3'd7;
        cyc();
        done_warp  = 3'd6;
        cyc();
        chk("oor_idle", 64'(out_valid), 64'(0));
        done_warp  = 3'd3;
        cyc();
        done_valid = 1'b0;
        cyc();
        chk("reissue_v", 64'(out_valid), 64'(1));
        chk("reissue_w", 64'(out_warp), 64'(3));

        // rdy low mid-burst: frozen, done ignored
        warp_valid = '1;
        mode       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_pcs();
            cyc();
            done_last();
        end
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_pcs();
            out_ready = i[0];
            cyc();
        end
        rdy       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_pcs();
            cyc();
            done_last();
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_pcs();
            warp_valid = N'($urandom);
            warp_stall = N'($urandom & $urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            rdy        = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            done_valid = ($urandom_range(0, 1) == 1);
            done_warp  = WW'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                int s;
                s = $urandom_range(0, N - 1);
                for (int k = 0; k < N; k++) begin
                    if (m_fl[(s + k) % N]) done_warp = WW'((s + k) % N);
                end
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
